video_effects_st_adapter: RTL and testbench



---
 rtl/video_pkg.sv | 22 ++
 rtl/video_sync_fifo.sv | 57 +++++
 rtl/video_effects_st_adapter.sv | 121 ++++++++++++
 tb/tb_video_effects_st_adapter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared constants, frame-state encoding and pipeline tag layout for the
// video effects adapter slice.
package video_pkg;

    localparam int PIX_W      = 16;
    localparam int EFFECT_W   = 8;
    localparam int FX_LATENCY = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } frame_state_t;

    // One tag travels alongside each pixel inside the effects pipeline.
    typedef struct packed {
        logic valid;
        logic sop;
        logic eop;
    } tag_t;

endpackage

// File: rtl/video_sync_fifo.sv
// Show-ahead synchronous FIFO with an occupancy count. DEPTH must be a
// power of two so the pointers wrap naturally.
module video_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign do_pop    = pop && (count != '0);
    // Empty reads return zero so the downstream port is clean after reset.
    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

    // NOTE: the storage array has no reset; the count alone decides which
    // entries are meaningful, so clearing the pointers is enough.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/video_effects_st_adapter.sv
// Avalon-ST wrapper around the fixed-latency video_effects pipeline: frame
// FSM, per-pixel tag shift register, credit-based backpressure and skid FIFO.
module video_effects_st_adapter #(
    parameter int DATA_W     = video_pkg::PIX_W,
    parameter int CFG_W      = video_pkg::EFFECT_W,
    parameter int FX_LATENCY = video_pkg::FX_LATENCY,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    input  logic              snk_sop,
    input  logic              snk_eop,
    output logic              snk_ready,
    output logic [DATA_W-1:0] fx_data_in,
    input  logic [DATA_W-1:0] fx_data_out,
    input  logic [CFG_W-1:0]  cfg_effect_in,
    output logic [CFG_W-1:0]  fx_effect,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    output logic              src_sop,
    output logic              src_eop,
    input  logic              src_ready,
    output logic [15:0]       frame_count,
    output logic [15:0]       drop_count,
    output logic              err_sop_in_frame
);

    import video_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    frame_state_t      state;
    frame_state_t      state_next;
    tag_t              tags [FX_LATENCY];
    logic [SUM_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W+1:0] fifo_head;
    logic              accept;
    logic              tag_in;
    logic              fifo_push;
    logic              fifo_pop;

    assign fx_data_in = snk_data;
    assign accept     = snk_valid && snk_ready;
    assign tag_in     = accept && ((state == ACTIVE) || snk_sop);
    assign fifo_push  = tags[FX_LATENCY-1].valid;
    assign src_valid  = (fifo_count != '0);
    assign fifo_pop   = src_valid && src_ready;
    assign {src_data, src_sop, src_eop} = fifo_head;

    // Credits cover both buffered and in-flight pixels, so a push can never
    // find the FIFO full.
    assign snk_ready = !reset && (state != DRAIN) &&
                       (({1'b0, fifo_count} + inflight) < SUM_W'(FIFO_DEPTH));

    always_comb begin
        inflight = '0;
        for (int i = 0; i < FX_LATENCY; i++) begin
            inflight = inflight + SUM_W'(tags[i].valid);
        end
    end

    // NOTE: assigning the default before the case keeps this purely
    // combinational; a path without an assignment would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept && snk_sop) state_next = ACTIVE;
            ACTIVE:  if (accept && snk_eop) state_next = DRAIN;
            DRAIN:   if (inflight == '0)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            fx_effect        <= '0;
            frame_count      <= '0;
            drop_count       <= '0;
            err_sop_in_frame <= 1'b0;
            for (int i = 0; i < FX_LATENCY; i++) begin
                tags[i] <= '0;
            end
        end else begin
            state    <= state_next;
            tags[0]  <= {tag_in, tag_in && snk_sop, tag_in && snk_eop};
            for (int i = 1; i < FX_LATENCY; i++) begin
                tags[i] <= tags[i-1];
            end
            // Configuration tracks the request only between frames.
            if ((state == IDLE) && !(accept && snk_sop)) begin
                fx_effect <= cfg_effect_in;
            end
            if ((state == ACTIVE) && accept && snk_eop) begin
                frame_count <= frame_count + 16'd1;
            end
            if ((state == IDLE) && accept && !snk_sop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
            err_sop_in_frame <= (state == ACTIVE) && accept && snk_sop;
        end
    end

    video_sync_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({fx_data_out, tags[FX_LATENCY-1].sop, tags[FX_LATENCY-1].eop}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_video_effects_st_adapter.sv
// Self-checking bench for video_effects_st_adapter: a behavioural effects
// pipeline, a frame-level reference model and an output scoreboard.
module tb_video_effects_st_adapter;

    localparam int LAT   = 6;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] snk_data = '0;
    logic        snk_valid = 1'b0;
    logic        snk_sop = 1'b0;
    logic        snk_eop = 1'b0;
    logic        snk_ready;
    logic [15:0] fx_data_in;
    logic [15:0] fx_data_out;
    logic [7:0]  cfg_effect_in = '0;
    logic [7:0]  fx_effect;
    logic [15:0] src_data;
    logic        src_valid;
    logic        src_sop;
    logic        src_eop;
    logic        src_ready = 1'b1;
    logic [15:0] frame_count;
    logic [15:0] drop_count;
    logic        err_sop_in_frame;

    video_effects_st_adapter u_dut (
        .clk              (clk),
        .reset            (reset),
        .snk_data         (snk_data),
        .snk_valid        (snk_valid),
        .snk_sop          (snk_sop),
        .snk_eop          (snk_eop),
        .snk_ready        (snk_ready),
        .fx_data_in       (fx_data_in),
        .fx_data_out      (fx_data_out),
        .cfg_effect_in    (cfg_effect_in),
        .fx_effect        (fx_effect),
        .src_data         (src_data),
        .src_valid        (src_valid),
        .src_sop          (src_sop),
        .src_eop          (src_eop),
        .src_ready        (src_ready),
        .frame_count      (frame_count),
        .drop_count       (drop_count),
        .err_sop_in_frame (err_sop_in_frame)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural effects pipeline: pixel XOR the configuration it was
    // sampled with, LAT cycles later.
    logic [15:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fx_data_in ^ {fx_effect, fx_effect};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign fx_data_out = pipe[LAT-1];

    typedef struct {
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    int    pop_cyc[$];
    bit    pop_sop[$];
    int    err_pulses = 0;
    int    exp_frames = 0;
    int    exp_drops = 0;
    bit    in_frame = 0;
    logic [7:0] cur_cfg = '0;
    logic [7:0] frame_eff = '0;
    bit    rand_bp = 0;
    beat_t mon_e;

    // Output scoreboard plus the no-overflow and credit-bound assertions.
    always @(negedge clk) begin
        if (!reset) begin
            if (src_valid && src_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data=%h sop=%b eop=%b, required no beat",
                             src_data, src_sop, src_eop);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({src_data, src_sop, src_eop} !== {mon_e.data, mon_e.sop, mon_e.eop}) begin
                        errors++;
                        $display("FAIL out_beat: got data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                                 src_data, src_sop, src_eop, mon_e.data, mon_e.sop, mon_e.eop);
                    end
                end
                pop_cyc.push_back(cyc);
                pop_sop.push_back(src_sop);
            end
            if (err_sop_in_frame) err_pulses++;
            checks++;
            if (u_dut.fifo_push && (u_dut.fifo_count == DEPTH) && !(src_valid && src_ready)) begin
                errors++;
                $display("FAIL fifo_overflow: push with count=%0d, required count<%0d", u_dut.fifo_count, DEPTH);
            end
            checks++;
            if (int'(u_dut.fifo_count) + int'(u_dut.inflight) > DEPTH) begin
                errors++;
                $display("FAIL credit_bound: got %0d, required <=%0d",
                         int'(u_dut.fifo_count) + int'(u_dut.inflight), DEPTH);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_bp) src_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Reference model of one accepted beat at frame level.
    task automatic model_accept(input logic [15:0] d, input logic sop, input logic eop);
        if (!in_frame) begin
            if (sop) begin
                in_frame  = 1;
                frame_eff = cur_cfg;
                exp_q.push_back('{data: d ^ {frame_eff, frame_eff}, sop: sop, eop: eop});
            end else begin
                exp_drops++;
            end
        end else begin
            exp_q.push_back('{data: d ^ {frame_eff, frame_eff}, sop: sop, eop: eop});
            if (eop) begin
                in_frame = 0;
                exp_frames++;
            end
        end
    endtask

    task automatic drive_beat(input logic [15:0] d, input logic sop, input logic eop, output bit acc);
        snk_data  = d;
        snk_sop   = sop;
        snk_eop   = eop;
        snk_valid = 1'b1;
        acc = snk_ready;
        if (acc) model_accept(d, sop, eop);
        step();
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic sop, input logic eop);
        bit acc = 0;
        int n = 0;
        while (!acc && n < 300) begin
            drive_beat(d, sop, eop, acc);
            n++;
        end
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: beat %h not accepted after %0d cycles", d, n);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!snk_ready && n < 500) begin
            step();
            n++;
        end
        if (!snk_ready) begin
            errors++;
            $display("FAIL ready_timeout: snk_ready=%b, required 1", snk_ready);
        end
    endtask

    task automatic prepare_frame(input logic [7:0] cfg);
        wait_ready();
        cfg_effect_in = cfg;
        cur_cfg = cfg;
        step();
        step();
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || src_valid) && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats missing, required 0", exp_q.size());
        end
        repeat (10) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (snk_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b, required 0", snk_ready);
        end
        checks++;
        if ({src_valid, src_sop, src_eop, src_data} !== 19'd0) begin
            errors++; $display("FAIL reset_src: got v=%b s=%b e=%b d=%h, required all 0", src_valid, src_sop, src_eop, src_data);
        end
        checks++;
        if ({fx_effect, frame_count, drop_count, err_sop_in_frame} !== 41'd0) begin
            errors++; $display("FAIL reset_regs: got fx=%h fc=%0d dc=%0d err=%b, required all 0", fx_effect, frame_count, drop_count, err_sop_in_frame);
        end
        reset = 1'b0;
        step();
        checks++;
        if (snk_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset: got %b, required 1", snk_ready);
        end
    endtask

    task automatic test_basic();
        logic [15:0] pix [4];
        int t0;
        bit acc;
        pix[0] = 16'h1111; pix[1] = 16'h2222; pix[2] = 16'h3333; pix[3] = 16'h4444;
        prepare_frame(8'h00);
        pop_cyc.delete();
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            drive_beat(pix[i], i == 0, i == 3, acc);
            checks++;
            if (!acc) begin
                errors++; $display("FAIL basic_accept: beat %0d ready=0, required 1", i);
            end
        end
        wait_drain();
        checks++;
        if (pop_cyc.size() != 4) begin
            errors++; $display("FAIL basic_count: got %0d beats, required 4", pop_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pop_cyc[i] != t0 + LAT + 1 + i) begin
                    errors++; $display("FAIL basic_latency: beat %0d in cycle %0d, required %0d", i, pop_cyc[i] - t0, LAT + 1 + i);
                end
            end
        end
        checks++;
        if (frame_count !== 16'd1) begin
            errors++; $display("FAIL basic_frame_count: got %0d, required 1", frame_count);
        end
    endtask

    task automatic test_drop();
        bit acc;
        int n0 = pop_cyc.size();
        for (int i = 0; i < 3; i++) begin
            drive_beat(16'($urandom), 1'b0, i == 2, acc);
            checks++;
            if (!acc) begin
                errors++; $display("FAIL drop_ready: beat %0d ready=0, required 1", i);
            end
        end
        repeat (12) step();
        checks++;
        if (pop_cyc.size() != n0) begin
            errors++; $display("FAIL drop_output: got %0d beats, required 0", pop_cyc.size() - n0);
        end
        checks++;
        if (drop_count !== 16'd3) begin
            errors++; $display("FAIL drop_count: got %0d, required 3", drop_count);
        end
    endtask

    task automatic test_cfg_freeze();
        prepare_frame(8'h20);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) cfg_effect_in = 8'h04;
            send_beat(16'($urandom), i == 0, i == 7);
            checks++;
            if (fx_effect !== 8'h20) begin
                errors++; $display("FAIL cfg_frozen: beat %0d fx_effect=%h, required 20", i, fx_effect);
            end
        end
        for (int i = 0; i < LAT; i++) begin
            checks++;
            if (fx_effect !== 8'h20) begin
                errors++; $display("FAIL cfg_drain: cycle %0d fx_effect=%h, required 20", i, fx_effect);
            end
            step();
        end
        wait_drain();
        prepare_frame(8'h04);
        checks++;
        if (fx_effect !== 8'h04) begin
            errors++; $display("FAIL cfg_next: got %h, required 04", fx_effect);
        end
        for (int i = 0; i < 4; i++) send_beat(16'($urandom), i == 0, i == 3);
        wait_drain();
    endtask

    task automatic test_backpressure();
        bit acc;
        int acc_n = 0;
        int n = 0;
        int fc0 = exp_frames;
        prepare_frame(8'h5A);
        src_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            drive_beat(16'($urandom), acc_n == 0, 1'b0, acc);
            if (acc) acc_n++;
        end
        checks++;
        if (acc_n != DEPTH) begin
            errors++; $display("FAIL bp_credit: accepted %0d, required %0d", acc_n, DEPTH);
        end
        checks++;
        if (snk_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready: got %b, required 0", snk_ready);
        end
        src_ready = 1'b1;
        while (acc_n < 40 && n < 300) begin
            drive_beat(16'($urandom), 1'b0, acc_n == 39, acc);
            if (acc) acc_n++;
            n++;
        end
        wait_drain();
        checks++;
        if (frame_count !== 16'(fc0 + 1)) begin
            errors++; $display("FAIL bp_frame_count: got %0d, required %0d", frame_count, fc0 + 1);
        end
    endtask

    task automatic test_sop_in_frame();
        int fc0, ep0;
        prepare_frame(8'h33);
        fc0 = frame_count;
        ep0 = err_pulses;
        for (int i = 0; i < 6; i++) send_beat(16'($urandom), i == 0 || i == 3, 1'b0);
        checks++;
        if (err_pulses != ep0 + 1) begin
            errors++; $display("FAIL err_pulse: got %0d pulses, required 1", err_pulses - ep0);
        end
        checks++;
        if (frame_count !== 16'(fc0)) begin
            errors++; $display("FAIL err_frame_count: got %0d, required %0d", frame_count, fc0);
        end
        checks++;
        if (snk_ready !== 1'b1) begin
            errors++; $display("FAIL err_still_active: ready=%b, required 1", snk_ready);
        end
        send_beat(16'($urandom), 1'b0, 1'b1);
        wait_drain();
        checks++;
        if (frame_count !== 16'(fc0 + 1) || err_pulses != ep0 + 1) begin
            errors++; $display("FAIL err_after_eop: fc=%0d pulses=%0d, required fc=%0d pulses=1", frame_count, err_pulses - ep0, fc0 + 1);
        end
    endtask

    task automatic test_reset_midframe();
        bit acc;
        int n0;
        prepare_frame(8'h11);
        src_ready = 1'b0;
        for (int i = 0; i < 9; i++) drive_beat(16'($urandom), i == 0, 1'b0, acc);
        step();
        checks++;
        if (u_dut.fifo_count != 4 || u_dut.inflight != 5) begin
            errors++; $display("FAIL rst_setup: buffered=%0d inflight=%0d, required 4 and 5", u_dut.fifo_count, u_dut.inflight);
        end
        reset = 1'b1;
        step();
        checks++;
        if (src_valid !== 1'b0 || snk_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid: src_valid=%b snk_ready=%b, required 0 0", src_valid, snk_ready);
        end
        reset = 1'b0;
        exp_q.delete();
        in_frame = 0;
        exp_frames = 0;
        exp_drops = 0;
        src_ready = 1'b1;
        step();
        drive_beat(16'hBEEF, 1'b0, 1'b0, acc);
        step();
        checks++;
        if (drop_count !== 16'd1 || frame_count !== 16'd0) begin
            errors++; $display("FAIL rst_counters: dc=%0d fc=%0d, required 1 0", drop_count, frame_count);
        end
        n0 = pop_sop.size();
        prepare_frame(8'h42);
        for (int i = 0; i < 4; i++) send_beat(16'($urandom), i == 0, i == 3);
        wait_drain();
        checks++;
        if (pop_sop.size() <= n0 || pop_sop[n0] !== 1'b1) begin
            errors++; $display("FAIL rst_first_sop: first output after reset not SOP, required SOP");
        end
    endtask

    task automatic test_random();
        bit acc;
        int len;
        rand_bp = 1;
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                for (int s = 0; s < int'($urandom_range(1, 2)); s++) drive_beat(16'($urandom), 1'b0, 1'b0, acc);
            end
            prepare_frame(8'($urandom));
            len = $urandom_range(2, 20);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) step();
                if ($urandom_range(0, 4) == 0) cfg_effect_in = 8'($urandom);
                send_beat(16'($urandom), i == 0, i == len - 1);
            end
        end
        rand_bp = 0;
        src_ready = 1'b1;
        wait_drain();
        checks++;
        if (frame_count !== 16'(exp_frames)) begin
            errors++; $display("FAIL rand_frame_count: got %0d, required %0d", frame_count, exp_frames);
        end
        checks++;
        if (drop_count !== 16'(exp_drops)) begin
            errors++; $display("FAIL rand_drop_count: got %0d, required %0d", drop_count, exp_drops);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_cfg_freeze();
        test_backpressure();
        test_sop_in_frame();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
